// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   FWD_*      : E-stage operand select encodings
//   state_e    : scheduler FSM states
//   MAX_STALL  : longest stall any single hazard can demand
//   reg_hit()  : "does stage S write register X that D/E actually reads"
package pipe_ctrl_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int MAX_STALL = 2;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_e;

  // $0 is hardwired zero, so a write to it never creates a dependency.
  function automatic logic reg_hit(input logic       wr,
                                   input logic [4:0] wreg,
                                   input logic [4:0] src,
                                   input logic       en);
    return wr & en & (wreg == src) & (src != 5'd0);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// E-stage forwarding select for one source operand.
//   src_i              : source register of the E instruction
//   wreg_m_i/regwr_m_i : M-stage destination and write enable
//   wreg_w_i/regwr_w_i : W-stage destination and write enable
//   sel_o              : FWD_MEM / FWD_WB / FWD_REG
module fwd_sel
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic [4:0] wreg_m_i,
  input  logic       regwr_m_i,
  input  logic [4:0] wreg_w_i,
  input  logic       regwr_w_i,
  output logic [1:0] sel_o
);

  // M holds the younger result, so it wins over W.
  always_comb begin
    sel_o = FWD_REG;
    if (reg_hit(regwr_m_i, wreg_m_i, src_i, 1'b1))      sel_o = FWD_MEM;
    else if (reg_hit(regwr_w_i, wreg_w_i, src_i, 1'b1)) sel_o = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard scheduler for the 5-stage CPU.
// Detects load-use and branch-operand hazards, sequences stall cycles via a
// RUN/STALL FSM, and drives the stall/flush controls and forwarding selects.
//   clk, rst_n               : clock, async active-low reset
//   rs_D/rt_D/use_*/branch_D/zero_D : D-stage instruction info
//   rs_E/rt_E, wreg_*/regwr_*/memtoreg_* : downstream stage info
//   pc_en_F, if_id_wr, if_id_flush, id_ex_flush : pipeline controls
//   fwd_rs_E/fwd_rt_E        : E operand selects; fwd_rs_D/fwd_rt_D : D compare selects
//   stall_cnt/flush_cnt      : saturating performance counters
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs_D,
  input  logic [4:0]       rt_D,
  input  logic             use_rs_D,
  input  logic             use_rt_D,
  input  logic             branch_D,
  input  logic             zero_D,
  input  logic [4:0]       rs_E,
  input  logic [4:0]       rt_E,
  input  logic [4:0]       wreg_E,
  input  logic [4:0]       wreg_M,
  input  logic [4:0]       wreg_W,
  input  logic             regwr_E,
  input  logic             regwr_M,
  input  logic             regwr_W,
  input  logic             memtoreg_E,
  input  logic             memtoreg_M,
  output logic             pc_en_F,
  output logic             if_id_wr,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       fwd_rs_E,
  output logic [1:0]       fwd_rt_E,
  output logic             fwd_rs_D,
  output logic             fwd_rt_D,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_e           state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic       hit_e_rs, hit_e_rt, hit_m_rs, hit_m_rt, hit_e, hit_m;
  logic [1:0] need;
  logic       stall, flush;
  logic [1:0] sel_rs_e, sel_rt_e;

  // ---------------- hazard detect ----------------
  assign hit_e_rs = reg_hit(regwr_E, wreg_E, rs_D, use_rs_D);
  assign hit_e_rt = reg_hit(regwr_E, wreg_E, rt_D, use_rt_D);
  assign hit_m_rs = reg_hit(regwr_M, wreg_M, rs_D, use_rs_D);
  assign hit_m_rt = reg_hit(regwr_M, wreg_M, rt_D, use_rt_D);
  assign hit_e    = hit_e_rs | hit_e_rt;
  assign hit_m    = hit_m_rs | hit_m_rt;

  // Overlapping hazards resolve in parallel, so the demand is the max.
  // The only 2-cycle case is a branch on a load still in E; it is tested
  // last so it overrides any 1-cycle demand.
  always_comb begin
    need = 2'd0;
    if (branch_D & memtoreg_M & hit_m)  need = 2'd1;
    if (memtoreg_E & hit_e)             need = 2'd1;
    if (branch_D & hit_e & ~memtoreg_E) need = 2'd1;
    if (branch_D & hit_e & memtoreg_E)  need = 2'(MAX_STALL);
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stall   = 1'b0;
    case (state_q)
      RUN: begin
        if (need != 2'd0) begin
          stall   = 1'b1;
          rem_d   = need - 2'd1;
          state_d = (need > 2'd1) ? STALL : RUN;
        end
      end
      STALL: begin
        // Hazard inputs are ignored here: the stall length was fixed on entry.
        stall   = 1'b1;
        rem_d   = rem_q - 2'd1;
        state_d = (rem_q <= 2'd1) ? RUN : STALL;
      end
      default: begin
        state_d = RUN;
        rem_d   = 2'd0;
      end
    endcase
    // Outputs sit at their idle values for as long as reset is held.
    stall = stall & rst_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      rem_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // ---------------- output decode ----------------
  // A taken branch held by a stall only flushes once the stall releases.
  assign flush       = rst_n & branch_D & zero_D & ~stall;
  assign pc_en_F     = ~stall;
  assign if_id_wr    = ~stall;
  assign id_ex_flush = stall;
  assign if_id_flush = flush;

  // Branch compare can only take M alu_out; load data is not ready yet.
  assign fwd_rs_D = rst_n & hit_m_rs & ~memtoreg_M;
  assign fwd_rt_D = rst_n & hit_m_rt & ~memtoreg_M;

  fwd_sel u_fwd_rs (
    .src_i    (rs_E),
    .wreg_m_i (wreg_M),
    .regwr_m_i(regwr_M),
    .wreg_w_i (wreg_W),
    .regwr_w_i(regwr_W),
    .sel_o    (sel_rs_e)
  );

  fwd_sel u_fwd_rt (
    .src_i    (rt_E),
    .wreg_m_i (wreg_M),
    .regwr_m_i(regwr_M),
    .wreg_w_i (wreg_W),
    .regwr_w_i(regwr_W),
    .sel_o    (sel_rt_e)
  );

  assign fwd_rs_E = rst_n ? sel_rs_e : FWD_REG;
  assign fwd_rt_E = rst_n ? sel_rt_e : FWD_REG;

  // ---------------- saturating counters ----------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
